// File: rtl/hamming_enc_seq.sv
// -----------------------------------------------------------------------------
// hamming_enc_seq
//
// Sequencer that reads NUM_MSG packed 11-bit messages (two bytes each, lo byte
// first) from data memory starting at SRC_BASE. It encodes each message as a
// Hamming (16,11) codeword with overall parity and writes the two codeword
// bytes starting at DST_BASE. While busy it owns the memory port. done is a
// level that stays high after the job until the next accepted start.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   start_i        job request, only honoured in IDLE
//   mem_addr_o     data-memory byte address
//   mem_rd_data_i  data-memory read data (combinational w.r.t. mem_addr_o)
//   mem_wr_en_o    data-memory write enable
//   mem_wr_data_o  data-memory write data
//   busy_o         job in progress
//   done_o         job complete (level)
//
// State table:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | waiting for start; done_o holds its last value
//   S_RD_LO  | drive source lo-byte address
//   S_RD_HI  | capture lo byte, drive source hi-byte address
//   S_WR_LO  | encode with live hi byte, write codeword lo byte
//   S_WR_HI  | write codeword hi byte, advance to the next message or finish
//   S_DONE   | drop busy, raise done
//
// All outputs are registered on the edge that leaves a state. The memory bus
// therefore trails the state register by one cycle, and the read data for an
// address issued from state X is captured while the FSM sits in the state
// after X.
// -----------------------------------------------------------------------------
module hamming_enc_seq #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30,
  parameter int unsigned AW       = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  output logic [AW-1:0] mem_addr_o,
  input  logic [7:0]    mem_rd_data_i,
  output logic          mem_wr_en_o,
  output logic [7:0]    mem_wr_data_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned    IW    = 7;
  localparam logic [IW-1:0]  LAST  = IW'(NUM_MSG - 1);
  localparam logic [AW-1:0]  SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0]  DST_A = AW'(DST_BASE);
  localparam logic [AW-1:0]  ONE_A = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [IW-1:0] i_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_byte_q;
  logic [AW-1:0] addr_q;
  logic          wr_en_q;
  logic [7:0]    wr_data_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] ofs_d;
  logic [AW-1:0] src_lo_d;
  logic [AW-1:0] dst_lo_d;
  logic [15:0]   cw_d;

  // Codeword layout: hi byte {d11..d5, p8}, lo byte {d4, d3, d2, p4, d1, p2, p1, p0}.
  function automatic logic [15:0] encode(input logic [7:0] lo, input logic [2:0] hi);
    logic [11:1] d;
    logic        p8, p4, p2, p1, p0;
    d  = {hi, lo};
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4], d[3], d[2], p4, d[1], p2, p1, p0};
  endfunction

  // Address arithmetic wraps modulo 2^AW.
  assign ofs_d    = AW'({i_q, 1'b0});
  assign src_lo_d = SRC_A + ofs_d;
  assign dst_lo_d = DST_A + ofs_d;

  // In S_WR_LO the bus still carries the source hi-byte address, so the live
  // read data is the hi byte of the current message.
  assign cw_d = encode(lo_q, mem_rd_data_i[2:0]);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      lo_q      <= '0;
      hi_byte_q <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            done_q  <= 1'b0;
            i_q     <= '0;
            state_q <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          addr_q  <= src_lo_d;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_RD_HI;
        end
        S_RD_HI: begin
          lo_q    <= mem_rd_data_i;
          addr_q  <= src_lo_d + ONE_A;
          state_q <= S_WR_LO;
        end
        S_WR_LO: begin
          addr_q    <= dst_lo_d;
          wr_en_q   <= 1'b1;
          wr_data_q <= cw_d[7:0];
          hi_byte_q <= cw_d[15:8];
          state_q   <= S_WR_HI;
        end
        S_WR_HI: begin
          addr_q    <= dst_lo_d + ONE_A;
          wr_en_q   <= 1'b1;
          wr_data_q <= hi_byte_q;
          if (i_q == LAST) begin
            state_q <= S_DONE;
          end else begin
            i_q     <= i_q + 1'b1;
            state_q <= S_RD_LO;
          end
        end
        S_DONE: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_data_o = wr_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_hamming_enc_seq.sv
module tb_hamming_enc_seq;

  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  logic [7:0] mem [256];
  logic [7:0] src_b [2*N];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int wr_count    = 0;

  hamming_enc_seq #(
    .NUM_MSG (N),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .AW      (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .mem_addr_o   (mem_addr),
    .mem_rd_data_i(rd_data),
    .mem_wr_en_o  (wr_en),
    .mem_wr_data_o(wr_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (wr_en) mem[mem_addr] <= wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: classic Hamming positions 1..15, parity at powers of two,
  // data filling the remaining positions in ascending order; bit 0 is overall parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] m);
    logic [15:0] cw;
    int j;
    cw = '0;
    j  = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[k] = m[j];
        j++;
      end
    end
    for (int b = 1; b < 16; b = b * 2)
      for (int k = 1; k < 16; k++)
        if (((k & b) != 0) && (k != b)) cw[b] = cw[b] ^ cw[k];
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] exp_msg(input int i);
    return ref_cw({src_b[2*i+1][2:0], src_b[2*i]});
  endfunction

  // Scoreboard monitor: every DUT write pops one expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_count = wr_count + 1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic push_job();
    logic [15:0] cw;
    wr_t w;
    for (int i = 0; i < N; i++) begin
      cw     = exp_msg(i);
      w.addr = 8'(DST + 2*i);
      w.data = cw[7:0];
      exp_q.push_back(w);
      w.addr = 8'(DST + 2*i + 1);
      w.data = cw[15:8];
      exp_q.push_back(w);
    end
  endtask

  task automatic load_msgs(input bit fixed);
    for (int i = 0; i < 2*N; i++) src_b[i] = 8'($urandom);
    if (fixed) begin
      src_b[0] = 8'h55; src_b[1] = 8'h05;
      src_b[2] = 8'h00; src_b[3] = 8'h00;
      src_b[4] = 8'hFF; src_b[5] = 8'h07;
      src_b[6] = 8'h55; src_b[7] = 8'hFD;
    end
    for (int i = 0; i < 2*N; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(SRC + i);
      ld_data = src_b[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_mem();
    logic [15:0] cw;
    for (int i = 0; i < N; i++) begin
      cw = exp_msg(i);
      check("dst_lo", 32'(mem[DST + 2*i]),     32'(cw[7:0]));
      check("dst_hi", 32'(mem[DST + 2*i + 1]), 32'(cw[15:8]));
    end
    for (int i = 0; i < 2*N; i++) check("src_kept", 32'(mem[SRC + i]), 32'(src_b[i]));
  endtask

  // Returns the edge (relative to the start-sampling edge) at which done rose, or -1.
  task automatic run_job(input bit extra, output int rise);
    int s;
    rise = -1;
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = extra && ((cyc + 1 == s + 10) || (cyc + 1 == s + 40));
      if (done) begin
        rise = cyc - s;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, r1, r2, wc0;
    rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done",    32'(done),    0);
    check("rst_busy",    32'(busy),    0);
    check("rst_wr_en",   32'(wr_en),   0);
    check("rst_addr",    32'(mem_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    wc0 = wr_count;
    repeat (20) @(negedge clk);
    check("idle_writes", wr_count - wc0, 0);
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);

    // Job A: known/extreme messages up front, stray starts at edges 10 and 40.
    load_msgs(1'b1);
    push_job();
    wc0 = wr_count;
    run_job(1'b1, r);
    check("done_edge_a", r, 4*N + 1);
    check("busy_at_done", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("writes_a", wr_count - wc0, 2*N);
    check("sb_empty_a", exp_q.size(), 0);
    check("done_held", 32'(done), 1);
    check("known_lo",  32'(mem[30]), 32'h5A);
    check("known_hi",  32'(mem[31]), 32'hAA);
    check("zero_lo",   32'(mem[32]), 32'h00);
    check("zero_hi",   32'(mem[33]), 32'h00);
    check("ones_lo",   32'(mem[34]), 32'hFF);
    check("ones_hi",   32'(mem[35]), 32'hFF);
    check("garb_lo",   32'(mem[36]), 32'h5A);
    check("garb_hi",   32'(mem[37]), 32'hAA);
    check_mem();

    // Job B: reset lands just after edge 23 while the codeword lo byte is on the bus.
    load_msgs(1'b0);
    push_job();
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 23) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_wr_en", 32'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_busy",  32'(busy),  0);
    check("abort_addr",  32'(mem_addr), 0);
    exp_q.delete();
    wc0 = wr_count;
    repeat (3) @(negedge clk);
    check("abort_no_writes", wr_count - wc0, 0);
    rst_n = 1'b1;
    load_msgs(1'b0);
    push_job();
    wc0 = wr_count;
    run_job(1'b0, r);
    check("done_edge_b", r, 4*N + 1);
    repeat (4) @(negedge clk);
    check("writes_b", wr_count - wc0, 2*N);
    check("sb_empty_b", exp_q.size(), 0);
    check_mem();

    // Job C: start held high -> back-to-back jobs with a one-cycle done pulse.
    load_msgs(1'b0);
    push_job();
    push_job();
    wc0 = wr_count;
    r1 = -1;
    r2 = -1;
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (r1 < 0) begin
        if (done) r1 = cyc - s;
      end else if (cyc - s == r1 + 1) begin
        check("done_pulse", 32'(done), 0);
      end else if (done) begin
        r2 = cyc - s;
        break;
      end
    end
    start = 1'b0;
    check("done_edge_c1", r1, 4*N + 1);
    check("done_edge_c2", r2, 2*(4*N + 1) + 1);
    repeat (6) @(negedge clk);
    check("writes_c", wr_count - wc0, 4*N);
    check("sb_empty_c", exp_q.size(), 0);
    check("idle_after_c", 32'(busy), 0);
    check_mem();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
